id_ex_pipeline_reg: RTL



---
 rtl/id_ex_pipeline_reg.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register for the 5-stage MIPS datapath.
// It captures the decode-stage results and presents them to EX one cycle later.
// The hazard unit can hold the contents (Stall) or replace them with a bubble (Flush).
// At each edge Flush has priority over Stall, and Stall over a normal load.
// Optional feature: define ID_EX_BUBBLE_COUNT_EN to build a saturating bubble
// counter and the Out_BubbleCount port. That build also adds the CNT_WIDTH parameter.
module id_ex_pipeline_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
`ifdef ID_EX_BUBBLE_COUNT_EN
    ,
    parameter int CNT_WIDTH      = 16
`endif
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic                      In_Valid,
    input  logic [DATA_WIDTH-1:0]     In_PC_Plus4,
    input  logic [DATA_WIDTH-1:0]     In_ReadData1,
    input  logic [DATA_WIDTH-1:0]     In_ReadData2,
    input  logic [DATA_WIDTH-1:0]     In_SignExtImm,
    input  logic [REG_ADDR_WIDTH-1:0] In_Rs,
    input  logic [REG_ADDR_WIDTH-1:0] In_Rt,
    input  logic [REG_ADDR_WIDTH-1:0] In_Rd,
    input  logic [8:0]                In_Ctrl,
    output logic                      Out_Valid,
    output logic [DATA_WIDTH-1:0]     Out_PC_Plus4,
    output logic [DATA_WIDTH-1:0]     Out_ReadData1,
    output logic [DATA_WIDTH-1:0]     Out_ReadData2,
    output logic [DATA_WIDTH-1:0]     Out_SignExtImm,
    output logic [REG_ADDR_WIDTH-1:0] Out_Rs,
    output logic [REG_ADDR_WIDTH-1:0] Out_Rt,
    output logic [REG_ADDR_WIDTH-1:0] Out_Rd,
    output logic [8:0]                Out_Ctrl,
    output logic [DATA_WIDTH-1:0]     Out_BranchOffset
`ifdef ID_EX_BUBBLE_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      Out_BubbleCount
`endif
);

    // The slot is EMPTY when it holds a bubble and FULL when it holds a real instruction.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t state_reg;
    slot_state_t state_next;

    logic [DATA_WIDTH-1:0]     pc_plus4_reg;
    logic [DATA_WIDTH-1:0]     read_data1_reg;
    logic [DATA_WIDTH-1:0]     read_data2_reg;
    logic [DATA_WIDTH-1:0]     sign_ext_imm_reg;
    logic [DATA_WIDTH-1:0]     branch_offset_reg;
    logic [REG_ADDR_WIDTH-1:0] rs_reg;
    logic [REG_ADDR_WIDTH-1:0] rt_reg;
    logic [REG_ADDR_WIDTH-1:0] rd_reg;
    logic [8:0]                ctrl_reg;

    // Slot state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= SLOT_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next slot state: a flush empties the slot and a stall holds it.
    // A load takes the validity of the incoming instruction.
    always_comb begin
        state_next = state_reg;
        if (Flush) begin
            state_next = SLOT_EMPTY;
        end else if (!Stall) begin
            state_next = In_Valid ? SLOT_FULL : SLOT_EMPTY;
        end
    end

    // Payload register: cleared on flush, held on stall, loaded otherwise.
    // An invalid instruction still loads its data fields, so forwarding
    // comparisons stay deterministic. Its control bits are forced to zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_plus4_reg      <= '0;
            read_data1_reg    <= '0;
            read_data2_reg    <= '0;
            sign_ext_imm_reg  <= '0;
            branch_offset_reg <= '0;
            rs_reg            <= '0;
            rt_reg            <= '0;
            rd_reg            <= '0;
            ctrl_reg          <= '0;
        end else if (Flush) begin
            pc_plus4_reg      <= '0;
            read_data1_reg    <= '0;
            read_data2_reg    <= '0;
            sign_ext_imm_reg  <= '0;
            branch_offset_reg <= '0;
            rs_reg            <= '0;
            rt_reg            <= '0;
            rd_reg            <= '0;
            ctrl_reg          <= '0;
        end else if (!Stall) begin
            pc_plus4_reg      <= In_PC_Plus4;
            read_data1_reg    <= In_ReadData1;
            read_data2_reg    <= In_ReadData2;
            sign_ext_imm_reg  <= In_SignExtImm;
            branch_offset_reg <= {In_SignExtImm[DATA_WIDTH-3:0], 2'b00};
            rs_reg            <= In_Rs;
            rt_reg            <= In_Rt;
            rd_reg            <= In_Rd;
            ctrl_reg          <= In_Valid ? In_Ctrl : 9'd0;
        end
    end

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic                 bubble_event;
    logic [CNT_WIDTH-1:0] bubble_cnt_reg;

    // A bubble is written whenever this edge empties the slot.
    // A stall-hold never writes a bubble, even if the slot is already empty.
    assign bubble_event = Flush || (!Stall && !In_Valid);

    // Saturating bubble counter; only reset clears it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bubble_cnt_reg <= '0;
        end else if (bubble_event && (bubble_cnt_reg != {CNT_WIDTH{1'b1}})) begin
            bubble_cnt_reg <= bubble_cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign Out_BubbleCount = bubble_cnt_reg;
`endif

    assign Out_Valid        = (state_reg == SLOT_FULL);
    assign Out_PC_Plus4     = pc_plus4_reg;
    assign Out_ReadData1    = read_data1_reg;
    assign Out_ReadData2    = read_data2_reg;
    assign Out_SignExtImm   = sign_ext_imm_reg;
    assign Out_BranchOffset = branch_offset_reg;
    assign Out_Rs           = rs_reg;
    assign Out_Rt           = rt_reg;
    assign Out_Rd           = rd_reg;
    assign Out_Ctrl         = ctrl_reg;

endmodule
